// File: rtl/rv_mc_ctrl.sv
// rtl/rv_mc_ctrl.sv - multicycle sequencer for an RV32I ALU/branch subset
// Owns pc, ir, instret and the sticky fault code; strobes are decoded from the state register.
module rv_mc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 15,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic [31:0]      pc,
    input  logic             alu_zero,
    output logic             alu_src_imm,
    output logic             alu_force_sub,
    output logic             rf_we,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state,
    output logic [1:0]       fault
);

    localparam int TW = $clog2(IMEM_TIMEOUT + 1);

    localparam logic [6:0]  OP_R   = 7'b0110011;
    localparam logic [6:0]  OP_I   = 7'b0010011;
    localparam logic [6:0]  OP_BR  = 7'b1100011;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] instret_q;
    logic [1:0]       fault_q;
    logic [TW-1:0]    tcnt_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_b;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic        br_taken;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign imm_b     = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_q + imm_b;
    assign br_taken  = (funct3 == 3'b000) ? alu_zero : ~alu_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= NOP;
            instret_q <= '0;
            fault_q   <= 2'd0;
            tcnt_q    <= '0;
        end else begin
            // counter only advances while waiting in FETCH, so it is zero on every FETCH entry
            if (state_q != S_FETCH) tcnt_q <= '0;
            case (state_q)
                S_IDLE: if (run) state_q <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        state_q <= S_DECODE;
                    end else if (tcnt_q == TW'(IMEM_TIMEOUT - 1)) begin
                        fault_q <= 2'd2;
                        state_q <= S_TRAP;
                    end else begin
                        tcnt_q  <= tcnt_q + TW'(1);
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_R || opcode == OP_I) begin
                        state_q <= S_EXEC;
                    end else if (opcode == OP_BR && funct3[2:1] == 2'b00) begin
                        state_q <= S_BRANCH;
                    end else begin
                        fault_q <= 2'd1;
                        state_q <= S_TRAP;
                    end
                end
                S_EXEC: state_q <= S_WB;
                S_WB: begin
                    pc_q      <= pc_plus4;
                    instret_q <= instret_q + CNT_W'(1);
                    state_q   <= run ? S_FETCH : S_IDLE;
                end
                S_BRANCH: begin
                    if (br_taken && br_target[1]) begin
                        fault_q <= 2'd3;
                        state_q <= S_TRAP;
                    end else begin
                        pc_q      <= br_taken ? br_target : pc_plus4;
                        instret_q <= instret_q + CNT_W'(1);
                        state_q   <= run ? S_FETCH : S_IDLE;
                    end
                end
                default: state_q <= S_TRAP;
            endcase
        end
    end

    assign imem_req      = (state_q == S_FETCH);
    assign imem_addr     = pc_q;
    assign ir            = ir_q;
    assign pc            = pc_q;
    assign alu_src_imm   = (state_q == S_EXEC) && (opcode == OP_I);
    assign alu_force_sub = (state_q == S_BRANCH);
    assign rf_we         = (state_q == S_WB) && (ir_q[11:7] != 5'd0);
    assign instret       = instret_q;
    assign state         = state_q;
    assign fault         = fault_q;

endmodule
